// File: rtl/sub_result_bcd_formatter.sv
// sub_result_bcd_formatter
// Takes the {carry, difference} result of a WIDTH-bit two's-complement
// subtractor and presents it as a sign flag plus a two-digit BCD magnitude.
// Conversion is an iterative double-dabble: one shift per clock. Valid/ready
// handshakes are used on both sides.
module sub_result_bcd_formatter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   diff_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             neg,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  // The magnitude needs WIDTH+1 bits because a zero difference with no carry
  // decodes to 2^WIDTH.
  localparam int MW = WIDTH + 1;
  // Counter must be able to hold WIDTH+1, the number of iterations.
  localparam int CW = $clog2(WIDTH + 2);
  // Shift register layout: {tens, ones, magnitude}.
  localparam int SW = 8 + MW;
  localparam logic [MW-1:0] TWO_POW_W = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   shreg;
  logic [CW-1:0]   cnt;
  logic            neg_pend;

  logic            capture;
  logic            neg_dec;
  logic [MW-1:0]   mag_dec;
  logic [3:0]      digit_adj [2];
  logic [SW-1:0]   shreg_next;
  logic            unused_tens_msb;

  // A result is taken only when both sides of the input handshake agree.
  assign capture = (state == IDLE) && in_ready && in_valid;

  // Sign/magnitude decode of the raw subtractor result. Carry-out set means
  // A>=B, so the difference is already the magnitude; otherwise negate it.
  always_comb begin
    neg_dec = 1'b0;
    mag_dec = {1'b0, diff_in[WIDTH-1:0]};
    if (!diff_in[WIDTH]) begin
      neg_dec = 1'b1;
      mag_dec = TWO_POW_W - {1'b0, diff_in[WIDTH-1:0]};
    end
  end

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before the
  // shift so that it carries correctly into the next decimal place.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit_adj
      assign digit_adj[gi] = (shreg[MW + 4*gi +: 4] >= 4'd5)
                           ? shreg[MW + 4*gi +: 4] + 4'd3
                           : shreg[MW + 4*gi +: 4];
    end
  endgenerate

  // Shift left by one; the magnitude MSB moves into the ones digit. The tens
  // MSB falls off the top, which is harmless since every magnitude is < 100.
  assign shreg_next      = {digit_adj[1][2:0], digit_adj[0], shreg[MW-1:0], 1'b0};
  assign unused_tens_msb = digit_adj[1][3];

  // Control FSM, conversion datapath and registered handshake/outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      neg       <= 1'b0;
      bcd_tens  <= 4'd0;
      bcd_ones  <= 4'd0;
      shreg     <= '0;
      cnt       <= '0;
      neg_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            in_ready <= 1'b0;
            neg_pend <= neg_dec;
            shreg    <= {8'd0, mag_dec};
            cnt      <= '0;
            state    <= CONVERT;
          end else begin
            // Also covers the first edge out of reset.
            in_ready <= 1'b1;
          end
        end

        CONVERT: begin
          if (cnt != LAST_CNT) begin
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
          end else begin
            // All iterations done: publish the digits and sign together.
            bcd_tens  <= shreg[SW-1 -: 4];
            bcd_ones  <= shreg[MW +: 4];
            neg       <= neg_pend;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          // Hold the result until the consumer takes it; no direct re-capture.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
